// File: rtl/rom_pkg.sv
// Shared constants and types for the lookup ROM and its sequential reader.
package rom_pkg;

    localparam int unsigned ROM_ADDR_W = 3;
    localparam int unsigned ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } rom_reader_state_t;

endpackage

// File: rtl/rom.sv
// Combinational lookup ROM; word 0 sits in the least-significant slice of CONTENTS.
module rom
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] CONTENTS = 64'h7E81_0FF0_AA55_CC33
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = CONTENTS[int'(addr_i)*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/rom_reader.sv
// Walks a wrapping ROM address range one word per cycle and streams the words
// out on a registered valid/ready interface, then pulses done.
module rom_reader
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W:0]   count_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] RemOne = {{ADDR_W{1'b0}}, 1'b1};

    rom_reader_state_t state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              load;
    logic              accept;

    // Refill the output register whenever it is empty or being drained this cycle.
    assign load   = (rem_q != '0) && (!out_valid_q || out_ready_i);
    assign accept = out_valid_q && out_ready_i;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (count_i != '0) begin
                        cur_addr_d = start_addr_i;
                        rem_d      = count_i;
                        state_d    = STREAM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STREAM: begin
                if (load) begin
                    out_data_d  = rom_data_i;
                    out_valid_d = 1'b1;
                    out_last_d  = (rem_q == RemOne);
                    cur_addr_d  = cur_addr_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                end else if (accept) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign rom_addr_o  = cur_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: commands push expected beats, a monitor pops on handshake.
module tb_rom_reader;
    import rom_pkg::*;

    localparam int AW = ROM_ADDR_W;
    localparam int DW = ROM_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    rom u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    rom_reader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .start_addr_i (start_addr),
        .count_i      (count),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .done_o       (done)
    );

    logic [DW-1:0] table_m [8] = '{8'h33, 8'hCC, 8'h55, 8'hAA, 8'hF0, 8'h0F, 8'h81, 8'h7E};

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    dones_seen = 0;
    int    exp_dones = 0;
    int    busy_cycles = 0;
    int    ready_mode = 0;
    logic  ready_pat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, between active edges.
    initial begin
        logic          stall_pending;
        logic [DW-1:0] stall_data;
        logic          stall_last;
        logic          prev_done;
        beat_t         e;
        stall_pending = 1'b0;
        prev_done     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pending = 1'b0;
                prev_done     = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (done) begin
                    dones_seen++;
                    check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                end
                prev_done = done;
                if (stall_pending) begin
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_data", {24'd0, out_data}, {24'd0, stall_data});
                    check("stall_last", {31'd0, out_last}, {31'd0, stall_last});
                end
                stall_pending = 1'b0;
                if (out_valid && out_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", {24'd0, out_data}, {24'd0, e.data});
                        check("beat_last", {31'd0, out_last}, {31'd0, e.last});
                    end
                end else if (out_valid) begin
                    stall_pending = 1'b1;
                    stall_data    = out_data;
                    stall_last    = out_last;
                end
            end
        end
    end

    // Ready driver: always high, a scripted pattern, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 1 && ready_pat.size() != 0) out_ready = ready_pat.pop_front();
            else out_ready = 1'b1;
        end
    end

    // Raises start for one cycle; returns just after the sampling edge E0.
    task automatic issue(input int sa, input int n);
        beat_t b;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(sa);
        count      = (AW+1)'(n);
        for (int i = 0; i < n; i++) begin
            b.data = table_m[(sa + i) % 8];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
        exp_dones++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (dones_seen != exp_dones && n < bound) begin
            @(posedge clk);
            n++;
        end
        check("done_count", dones_seen, exp_dones);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rom_addr", {29'd0, rom_addr}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full table, no stalls; also measures busy length.
        busy_cycles = 0;
        issue(0, 8);
        wait_idle(40);
        @(posedge clk);
        check("busy_cycles_n8", busy_cycles, 10);

        // Wrap 7->0, with a start pulse mid-stream that must be ignored.
        issue(6, 4);
        #1;
        start = 1'b1; start_addr = 3'd1; count = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(40);

        // Backpressure pattern.
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ready_mode = 1;
        issue(2, 3);
        wait_idle(40);
        ready_mode = 0;

        // count==0: done/busy right after E0, start during busy ignored.
        base = beats_seen;
        issue(3, 0);
        check("cnt0_done", {31'd0, done}, 32'd1);
        check("cnt0_busy", {31'd0, busy}, 32'd1);
        start = 1'b1; start_addr = 3'd0; count = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(20);
        repeat (10) @(posedge clk);
        check("cnt0_no_beats", beats_seen - base, 0);
        check("cnt0_no_extra_done", dones_seen, exp_dones);

        // Reset mid-stream after the second beat.
        base = beats_seen;
        issue(0, 8);
        n = 0;
        while (beats_seen < base + 2 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("rst_mid_reached", {31'd0, beats_seen >= base + 2}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_last", {31'd0, out_last}, 32'd0);
        check("rst_mid_rom_addr", {29'd0, rom_addr}, 32'd0);
        exp_q.delete();
        exp_dones--;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check("rst_mid_no_done", dones_seen, exp_dones);
        issue(4, 2);
        wait_idle(40);

        // Nine words from 7 re-reads address 7.
        issue(7, 9);
        wait_idle(60);

        // Random commands with random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            wait_idle(200);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
